// File: rtl/ipf_lcu_feeder_if.sv
// ---------------------------------------------------------------------------
// ipf_lcu_feeder_if : feeder <-> memories / IPF signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ipf_lcu_feeder_if #(
  parameter int IMG_W = 128
);
  localparam int c_AW = 2 * $clog2(IMG_W);
  localparam int c_LW = $clog2(IMG_W / 16);

  logic                  start;
  logic [1:0]            lcu_size_i;
  logic                  img_rd;
  logic [c_AW-1:0]       img_addr;
  logic [7:0]            img_q;
  logic                  par_rd;
  logic [2*c_LW-1:0]     par_addr;
  logic [23:0]           par_q;
  logic                  busy;
  logic                  in_en;
  logic [7:0]            din;
  logic [1:0]            ipf_type;
  logic [4:0]            ipf_band_pos;
  logic                  ipf_wo_class;
  logic [15:0]           ipf_offset;
  logic [c_LW-1:0]       lcu_x;
  logic [c_LW-1:0]       lcu_y;
  logic [1:0]            lcu_size;
  logic                  done;

  modport master (
    input  start, lcu_size_i, img_q, par_q, busy,
    output img_rd, img_addr, par_rd, par_addr, in_en, din,
           ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size, done
  );

  modport slave (
    output start, lcu_size_i, img_q, par_q, busy,
    input  img_rd, img_addr, par_rd, par_addr, in_en, din,
           ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size, done
  );
endinterface

`default_nettype wire

// File: rtl/ipf_lcu_feeder.sv
// ---------------------------------------------------------------------------
// ipf_lcu_feeder : streams a frame to IPF in LCU raster order with skid FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ipf_lcu_feeder #(
  parameter int IMG_W      = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  ipf_lcu_feeder_if.master bus
);
  localparam int c_PW = $clog2(IMG_W);
  localparam int c_LW = $clog2(IMG_W / 16);
  localparam int c_IW = 2 * c_LW;
  localparam int c_FW = $clog2(FIFO_DEPTH);
  localparam int c_CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_PFETCH = 3'd1;
  localparam logic [2:0] c_PWAIT  = 3'd2;
  localparam logic [2:0] c_STREAM = 3'd3;
  localparam logic [2:0] c_DRAIN  = 3'd4;
  localparam logic [2:0] c_DONE   = 3'd5;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [1:0]      r_size;
  logic [c_LW-1:0] r_cx;
  logic [c_LW-1:0] r_cy;
  logic [c_PW-1:0] r_px;
  logic [c_PW-1:0] r_py;
  logic            r_pend;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_FW-1:0] r_wp;
  logic [c_FW-1:0] r_rp;
  logic [c_CW-1:0] r_cnt;
  logic            r_in_en;
  logic [7:0]      r_din;
  logic [23:0]     r_par;
  logic [c_LW-1:0] r_lx;
  logic [c_LW-1:0] r_ly;

  logic [2:0]      w_nsh;
  logic [c_PW-1:0] w_nmax;
  logic [c_LW-1:0] w_lmax;
  logic            w_last_pix;
  logic            w_last_lcu;
  logic [c_PW-1:0] w_row;
  logic [c_PW-1:0] w_col;
  logic [c_IW-1:0] w_pidx;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;

  assign w_nsh      = 3'd4 + {1'b0, r_size};
  assign w_nmax     = c_PW'((32'd16 << r_size) - 32'd1);
  assign w_lmax     = c_LW'((32'(IMG_W / 16) >> r_size) - 32'd1);
  assign w_last_pix = (r_px == w_nmax) && (r_py == w_nmax);
  assign w_last_lcu = (r_cx == w_lmax) && (r_cy == w_lmax);
  assign w_row      = c_PW'(32'(r_cy) << w_nsh) + r_py;
  assign w_col      = c_PW'(32'(r_cx) << w_nsh) + r_px;
  assign w_pidx     = c_IW'((32'(r_cy) << (c_LW - 32'(r_size))) + 32'(r_cx));

  // Reads in flight count against FIFO room so a stalled IPF can never overflow it
  assign w_issue = (r_state == c_STREAM) &&
                   ((32'(r_cnt) + 32'(r_pend)) < (FIFO_DEPTH - 1));
  assign w_push  = r_pend;
  assign w_pop   = !bus.busy && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (bus.start && (bus.lcu_size_i != 2'd3)) w_next = c_PFETCH;
      c_PFETCH: w_next = c_PWAIT;
      c_PWAIT:  w_next = c_STREAM;
      c_STREAM: if (w_issue && w_last_pix) w_next = c_DRAIN;
      c_DRAIN:  if ((r_cnt == '0) && !r_pend) w_next = w_last_lcu ? c_DONE : c_PFETCH;
      c_DONE:   w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    bus.img_rd   = w_issue;
    bus.par_rd   = 1'b0;
    bus.par_addr = '0;
    bus.done     = 1'b0;
    case (r_state)
      c_PFETCH: begin
        bus.par_rd   = 1'b1;
        bus.par_addr = w_pidx;
      end
      c_DONE:   bus.done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= bus.img_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_size  <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_pend  <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_in_en <= 1'b0;
      r_din   <= '0;
      r_par   <= '0;
      r_lx    <= '0;
      r_ly    <= '0;
    end else begin
      r_pend  <= w_issue;
      r_in_en <= w_pop;

      if (w_issue) begin
        if (r_px == w_nmax) begin
          r_px <= '0;
          r_py <= r_py + c_PW'(1);
        end else begin
          r_px <= r_px + c_PW'(1);
        end
      end

      if (w_push) r_wp <= (r_wp == c_FW'(FIFO_DEPTH - 1)) ? '0 : r_wp + c_FW'(1);
      if (w_pop) begin
        r_din <= r_mem[r_rp];
        r_rp  <= (r_rp == c_FW'(FIFO_DEPTH - 1)) ? '0 : r_rp + c_FW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CW'(1);
        2'b01:   r_cnt <= r_cnt - c_CW'(1);
        default: ;
      endcase

      case (r_state)
        c_IDLE: if (w_next == c_PFETCH) begin
          r_size <= bus.lcu_size_i;
          r_cx   <= '0;
          r_cy   <= '0;
        end
        // FIFO is already drained here, so parameters never change under a live beat
        c_PWAIT: begin
          r_par <= bus.par_q;
          r_lx  <= r_cx;
          r_ly  <= r_cy;
          r_px  <= '0;
          r_py  <= '0;
        end
        c_DRAIN: if (w_next == c_PFETCH) begin
          if (r_cx == w_lmax) begin
            r_cx <= '0;
            r_cy <= r_cy + c_LW'(1);
          end else begin
            r_cx <= r_cx + c_LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.img_addr     = {w_row, w_col};
  assign bus.in_en        = r_in_en;
  assign bus.din          = r_din;
  assign bus.ipf_type     = r_par[23:22];
  assign bus.ipf_band_pos = r_par[21:17];
  assign bus.ipf_wo_class = r_par[16];
  assign bus.ipf_offset   = r_par[15:0];
  assign bus.lcu_x        = r_lx;
  assign bus.lcu_y        = r_ly;
  assign bus.lcu_size     = r_size;

endmodule

`default_nettype wire

// File: tb/tb_ipf_lcu_feeder.sv
// ---------------------------------------------------------------------------
// tb_ipf_lcu_feeder : frame-level checks of the LCU feeder against a pixel-order model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ipf_lcu_feeder;
  localparam int IMG_W      = 128;
  localparam int FIFO_DEPTH = 4;
  localparam int NPIX       = IMG_W * IMG_W;

  typedef struct {
    int size;
    int pct;
    int img_rand;
    int stray_at;
    int exp_pix;
    int exp_lcu;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ipf_lcu_feeder_if #(.IMG_W(IMG_W)) bus ();
  ipf_lcu_feeder #(.IMG_W(IMG_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0]  img_mem [NPIX];
  logic [23:0] par_mem [64];

  always @(posedge clk) begin
    if (bus.img_rd) bus.img_q <= img_mem[bus.img_addr];
    if (bus.par_rd) bus.par_q <= par_mem[bus.par_addr];
  end

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   m_size = 0;
  int   busy_pct = 0;
  int   hold = 0;
  int   start_cyc = 0;
  int   beats, dones, lcu_chg, last_lcu, n_par, busy_viol, issue_viol;
  int   max_occ, rd_issued, first_cyc, last_beat_cyc;
  logic saved_busy = 1'b0;
  vec_t vecs [3];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Pixel k of the frame: LCU raster, then pixel raster inside the LCU
  function automatic logic [63:0] exp_beat(input int k);
    int n, lpr, lcu, w, lx, ly, addr;
    n    = 16 << m_size;
    lpr  = IMG_W / n;
    lcu  = k / (n * n);
    w    = k % (n * n);
    lx   = lcu % lpr;
    ly   = lcu / lpr;
    addr = (ly * n + w / n) * IMG_W + lx * n + w % n;
    return {24'd0, img_mem[addr], 3'(lx), 3'(ly), 2'(m_size), par_mem[lcu]};
  endfunction

  function automatic logic [63:0] all_outputs();
    return {bus.img_rd, bus.img_addr, bus.par_rd, bus.par_addr, bus.in_en, bus.din,
            bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset,
            bus.lcu_x, bus.lcu_y, bus.lcu_size, bus.done};
  endfunction

  task automatic clear_stats();
    beats = 0; dones = 0; lcu_chg = 0; last_lcu = -1; n_par = 0;
    busy_viol = 0; issue_viol = 0; max_occ = 0; rd_issued = 0;
    first_cyc = 0; last_beat_cyc = -10;
  endtask

  task automatic fill(input int rnd);
    logic [31:0] r;
    for (int a = 0; a < NPIX; a++) begin
      r = $urandom;
      img_mem[a] = (rnd != 0) ? r[7:0] : 8'(a);
    end
    for (int k = 0; k < 64; k++) begin
      r = $urandom;
      par_mem[k] = {r[7:0], 16'(k)};
    end
  endtask

  // One clock: observe at the falling edge, then set busy for the next rising edge
  task automatic step();
    int occ;
    logic [63:0] act;
    @(negedge clk);
    cyc++;
    if (bus.in_en === 1'b1) begin
      if (saved_busy) busy_viol++;
      if (beats == 0) first_cyc = cyc;
      if (int'({bus.lcu_y, bus.lcu_x}) != last_lcu) begin
        lcu_chg++;
        last_lcu = int'({bus.lcu_y, bus.lcu_x});
      end
      act = {24'd0, bus.din, bus.lcu_x, bus.lcu_y, bus.lcu_size,
             bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset};
      if (beats < NPIX) check("beat", act, exp_beat(beats));
      else              check("extra_beat", 64'(beats), 64'(NPIX - 1));
      beats++;
      last_beat_cyc = cyc;
    end
    if (bus.done === 1'b1) begin
      dones++;
      check("done_timing", 64'(cyc), 64'(last_beat_cyc + 1));
    end
    if (bus.par_rd === 1'b1) n_par++;
    occ = rd_issued - beats;
    if (occ > max_occ) max_occ = occ;
    if (bus.img_rd === 1'b1) begin
      if (occ >= FIFO_DEPTH - 1) issue_viol++;
      rd_issued++;
    end
    if (hold > 0) begin
      saved_busy = 1'b1;
      hold--;
    end else begin
      saved_busy = ($urandom_range(99) < busy_pct);
    end
    bus.busy = saved_busy;
  endtask

  task automatic start_frame(input int size);
    clear_stats();
    m_size         = size;
    bus.lcu_size_i = 2'(size);
    bus.start      = 1'b1;
    start_cyc      = cyc;
    step();
    bus.start      = 1'b0;
  endtask

  task automatic run_until(input int max_beats, input int stray_at);
    int guard = 0;
    bit strayed = 1'b0;
    while (dones == 0 && beats < max_beats && guard < 60000) begin
      if (!strayed && stray_at > 0 && beats >= stray_at) begin
        strayed        = 1'b1;
        bus.start      = 1'b1;
        bus.lcu_size_i = 2'((m_size == 0) ? 1 : 0);
        step();
        bus.start      = 1'b0;
        bus.lcu_size_i = 2'(m_size);
      end else begin
        step();
      end
      guard++;
    end
    check("frame_timeout", 64'(guard >= 60000), 64'd0);
  endtask

  initial begin
    int b0, np0, rd0;
    logic [31:0] seed;
    seed = $urandom(32'd20240);
    reset = 1'b1;
    bus.start = 1'b0;
    bus.lcu_size_i = 2'd0;
    bus.busy = 1'b0;
    vecs[0] = '{2, 0,  0, 3000, NPIX, 4};
    vecs[1] = '{0, 0,  1, 0,    NPIX, 64};
    vecs[2] = '{1, 50, 1, 0,    NPIX, 16};
    clear_stats();

    step(); step();
    check("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b0;
    step();

    // Illegal size must not start a frame
    bus.lcu_size_i = 2'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    check("illegal_size_par_rd", 64'(n_par), 64'd0);
    check("illegal_size_beats", 64'(beats), 64'd0);

    for (int i = 0; i < 3; i++) begin
      fill(vecs[i].img_rand);
      busy_pct = vecs[i].pct;
      start_frame(vecs[i].size);
      run_until(NPIX + 1, vecs[i].stray_at);
      repeat (8) step();
      check("pixel_count", 64'(beats), 64'(vecs[i].exp_pix));
      check("lcu_count", 64'(lcu_chg), 64'(vecs[i].exp_lcu));
      check("par_reads", 64'(n_par), 64'(vecs[i].exp_lcu));
      check("done_count", 64'(dones), 64'd1);
      check("busy_respected", 64'(busy_viol), 64'd0);
      check("issue_rule", 64'(issue_viol), 64'd0);
      check("max_occupancy_ok", 64'(max_occ <= FIFO_DEPTH - 1), 64'd1);
      if (vecs[i].pct == 0) check("first_latency", 64'(first_cyc - start_cyc), 64'd6);
    end

    // Busy held for 20 cycles mid-LCU, then reset at pixel 1000 and replay
    fill(1);
    busy_pct = 0;
    start_frame(1);
    run_until(500, 0);
    hold = 20;
    step();
    b0 = beats;
    repeat (20) step();
    check("busy_hold_no_beats", 64'(beats), 64'(b0));
    check("busy_hold_fill", 64'(rd_issued - beats), 64'(FIFO_DEPTH - 1));
    run_until(1000, 0);
    check("busy_hold_order_violations", 64'(busy_viol + issue_viol), 64'd0);

    reset = 1'b1;
    step();
    check("midframe_reset_outputs", all_outputs(), 64'd0);
    reset = 1'b0;
    b0 = beats; np0 = n_par; rd0 = rd_issued;
    repeat (6) step();
    check("post_reset_no_beats", 64'(beats), 64'(b0));
    check("post_reset_idle", 64'((n_par - np0) + (rd_issued - rd0)), 64'd0);

    start_frame(1);
    run_until(2000, 0);
    check("replay_pixels", 64'(beats), 64'd2000);
    check("replay_first_latency", 64'(first_cyc - start_cyc), 64'd6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
